// File: rtl/line_burst_pkg.sv
// Shared types and constants for the line-to-burst responder.
// A 256-bit line moves over the memory bus as four ascending 64-bit beats.
package line_burst_pkg;

   localparam int LINE_W = 256;
   localparam int BEAT_W = 64;
   localparam int BEATS  = LINE_W / BEAT_W;
   localparam int CNT_W  = $clog2(BEATS);
   localparam int OFF_W  = $clog2(LINE_W / 8);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WBEATS,
      RBEATS,
      RESP
   } state_t;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
   } burst_cmd_t;

   // Line alignment drops the byte offset within the line.
   function automatic logic [31:0] line_align(input logic [31:0] a);
      return {a[31:OFF_W], {OFF_W{1'b0}}};
   endfunction

endpackage

// File: rtl/line_beat_buf.sv
// Line register viewed as BEATS slots: whole-line load for write splitting,
// per-slot write for read assembly, and an indexed slot read.
module line_beat_buf
   import line_burst_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [LINE_W-1:0] load_line,
   input  logic              beat_we,
   input  logic [CNT_W-1:0]  beat_idx,
   input  logic [BEAT_W-1:0] beat_data,
   output logic [LINE_W-1:0] line,
   output logic [BEAT_W-1:0] beat_out
);

   logic [BEATS-1:0][BEAT_W-1:0] slots;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slots <= '0;
      end else begin
         for (int b = 0; b < BEATS; b++) begin
            if (load)
               slots[b] <= load_line[b*BEAT_W +: BEAT_W];
            else if (beat_we && beat_idx == CNT_W'(b))
               slots[b] <= beat_data;
         end
      end
   end

   assign line     = slots;
   assign beat_out = slots[beat_idx];

endmodule

// File: rtl/line_burst_responder.sv
// Turns held line read/write requests into 4-beat memory bursts and
// answers with a one-cycle line_resp; every output decodes registered state.
module line_burst_responder
   import line_burst_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              line_read,
   input  logic              line_write,
   input  logic [31:0]       line_address,
   input  logic [LINE_W-1:0] line_wdata,
   output logic              line_resp,
   output logic [LINE_W-1:0] line_rdata,
   output logic              mem_cmd_valid,
   input  logic              mem_cmd_ready,
   output logic              mem_cmd_write,
   output logic [31:0]       mem_cmd_addr,
   output logic              mem_wvalid,
   input  logic              mem_wready,
   output logic [BEAT_W-1:0] mem_wdata,
   input  logic              mem_rvalid,
   input  logic [BEAT_W-1:0] mem_rdata
);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   burst_cmd_t        cmd;
   logic [LINE_W-1:0] buf_line;
   logic              take;
   logic              rd_beat;
   logic              last;

   assign take    = (state == IDLE) && (line_read || line_write);
   assign rd_beat = (state == RBEATS) && mem_rvalid;
   assign last    = (cnt == CNT_W'(BEATS - 1));

   assign mem_cmd_write = cmd.write;
   assign mem_cmd_addr  = cmd.addr;

   // One buffer serves both directions: it holds the write line during a
   // write burst and collects beats during a read; line_rdata is separate
   // so a previous read result survives until the next read finishes.
   line_beat_buf u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (take),
      .load_line (line_wdata),
      .beat_we   (rd_beat),
      .beat_idx  (cnt),
      .beat_data (mem_rdata),
      .line      (buf_line),
      .beat_out  (mem_wdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         cmd           <= '0;
         line_resp     <= 1'b0;
         mem_cmd_valid <= 1'b0;
         mem_wvalid    <= 1'b0;
         line_rdata    <= '0;
      end else begin
         case (state)
            IDLE: begin
               line_resp <= 1'b0;
               if (take) begin
                  cmd.write     <= line_write;
                  cmd.addr      <= line_align(line_address);
                  mem_cmd_valid <= 1'b1;
                  state         <= CMD;
               end
            end
            CMD: begin
               if (mem_cmd_ready) begin
                  mem_cmd_valid <= 1'b0;
                  cnt           <= '0;
                  if (cmd.write) begin
                     mem_wvalid <= 1'b1;
                     state      <= WBEATS;
                  end else begin
                     state      <= RBEATS;
                  end
               end
            end
            WBEATS: begin
               if (mem_wready) begin
                  cnt <= cnt + CNT_W'(1);
                  if (last) begin
                     mem_wvalid <= 1'b0;
                     line_resp  <= 1'b1;
                     state      <= RESP;
                  end
               end
            end
            RBEATS: begin
               if (mem_rvalid) begin
                  cnt <= cnt + CNT_W'(1);
                  if (last) begin
                     // Final beat is the top slot; merge it in directly.
                     line_rdata <= {mem_rdata, buf_line[LINE_W-BEAT_W-1:0]};
                     line_resp  <= 1'b1;
                     state      <= RESP;
                  end
               end
            end
            RESP: begin
               line_resp <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               line_resp     <= 1'b0;
               mem_cmd_valid <= 1'b0;
               mem_wvalid    <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_burst_responder.sv
// Directed bench for line_burst_responder: reads, stalled writes, command
// backpressure, back-to-back, read+write collision and mid-burst reset.
module tb_line_burst_responder;
   import line_burst_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              line_read = 1'b0;
   logic              line_write = 1'b0;
   logic [31:0]       line_address = '0;
   logic [LINE_W-1:0] line_wdata = '0;
   logic              line_resp;
   logic [LINE_W-1:0] line_rdata;
   logic              mem_cmd_valid;
   logic              mem_cmd_ready = 1'b0;
   logic              mem_cmd_write;
   logic [31:0]       mem_cmd_addr;
   logic              mem_wvalid;
   logic              mem_wready = 1'b0;
   logic [BEAT_W-1:0] mem_wdata;
   logic              mem_rvalid = 1'b0;
   logic [BEAT_W-1:0] mem_rdata = '0;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0][63:0] rb, wb, qb, xb, nb, zb;

   line_burst_responder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .line_read     (line_read),
      .line_write    (line_write),
      .line_address  (line_address),
      .line_wdata    (line_wdata),
      .line_resp     (line_resp),
      .line_rdata    (line_rdata),
      .mem_cmd_valid (mem_cmd_valid),
      .mem_cmd_ready (mem_cmd_ready),
      .mem_cmd_write (mem_cmd_write),
      .mem_cmd_addr  (mem_cmd_addr),
      .mem_wvalid    (mem_wvalid),
      .mem_wready    (mem_wready),
      .mem_wdata     (mem_wdata),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rb = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      wb = {64'hD3D3_0000_0000_0003, 64'hC2C2_0000_0000_0002,
            64'hB1B1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
      qb = {64'h0F0F_0F0F_0000_0004, 64'h0E0E_0E0E_0000_0003,
            64'h0D0D_0D0D_0000_0002, 64'h0C0C_0C0C_0000_0001};
      xb = {64'h7777_0000_0000_0033, 64'h6666_0000_0000_0022,
            64'h5555_0000_0000_0011, 64'h4444_0000_0000_0000};
      zb = {64'hDEAD_0000_0000_0003, 64'hDEAD_0000_0000_0002,
            64'hDEAD_0000_0000_0001, 64'hDEAD_0000_0000_0000};
      nb = {64'h9999_AAAA_0000_0004, 64'h9999_AAAA_0000_0003,
            64'h9999_AAAA_0000_0002, 64'h9999_AAAA_0000_0001};

      // Reset state
      #12;
      chk1("rst_resp", line_resp, 1'b0);
      chk1("rst_cmdv", mem_cmd_valid, 1'b0);
      chk1("rst_wv", mem_wvalid, 1'b0);
      chk1("rst_cmdw", mem_cmd_write, 1'b0);
      chkw("rst_addr", 256'(mem_cmd_addr), 256'h0);
      chkw("rst_wdata", 256'(mem_wdata), 256'h0);
      chkw("rst_rdata", line_rdata, 256'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick;

      // Zero-wait read
      line_read = 1'b1; line_address = 32'h0000_1234; mem_cmd_ready = 1'b1;
      chk1("rd_c0_cmdv", mem_cmd_valid, 1'b0);
      tick;
      chk1("rd_c1_cmdv", mem_cmd_valid, 1'b1);
      chkw("rd_c1_addr", 256'(mem_cmd_addr), 256'h0000_1220);
      chk1("rd_c1_cmdw", mem_cmd_write, 1'b0);
      line_address = 32'hFFFF_FFFF;
      tick;
      chk1("rd_c2_cmdv", mem_cmd_valid, 1'b0);
      mem_rvalid = 1'b1; mem_rdata = rb[0];
      tick; mem_rdata = rb[1];
      tick; mem_rdata = rb[2];
      tick; mem_rdata = rb[3];
      chk1("rd_c5_resp", line_resp, 1'b0);
      tick;
      mem_rvalid = 1'b0;
      chk1("rd_c6_resp", line_resp, 1'b1);
      chkw("rd_c6_rdata", line_rdata, rb);
      line_read = 1'b0;
      tick;
      chk1("rd_c7_resp", line_resp, 1'b0);
      chkw("rd_c7_rdata_hold", line_rdata, rb);

      // Write with wready stalls every other cycle
      line_write = 1'b1; line_address = 32'h8000_0047; line_wdata = wb;
      tick;
      chk1("wr_c1_cmdv", mem_cmd_valid, 1'b1);
      chk1("wr_c1_cmdw", mem_cmd_write, 1'b1);
      chkw("wr_c1_addr", 256'(mem_cmd_addr), 256'h8000_0040);
      line_wdata = '0;
      tick;
      for (int b = 0; b < 4; b++) begin
         mem_wready = 1'b0;
         chk1("wr_wv", mem_wvalid, 1'b1);
         chk1("wr_noresp", line_resp, 1'b0);
         chkw("wr_beat", 256'(mem_wdata), 256'(wb[b]));
         tick;
         chkw("wr_beat_stable", 256'(mem_wdata), 256'(wb[b]));
         mem_wready = 1'b1;
         tick;
      end
      mem_wready = 1'b0;
      chk1("wr_resp", line_resp, 1'b1);
      chk1("wr_wv_done", mem_wvalid, 1'b0);
      chkw("wr_rdata_hold", line_rdata, rb);
      line_write = 1'b0;
      tick;

      // Back-to-back read with 5 cycles of command backpressure
      line_read = 1'b1; line_address = 32'h0000_0FFF; mem_cmd_ready = 1'b0;
      chk1("bp_c0_resp", line_resp, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         tick;
         chk1("bp_cmdv", mem_cmd_valid, 1'b1);
         chkw("bp_addr", 256'(mem_cmd_addr), 256'h0000_0FE0);
         chk1("bp_wv", mem_wvalid, 1'b0);
         line_address = 32'h1234_5678 + 32'(k);
      end
      tick;
      mem_cmd_ready = 1'b1;
      chk1("bp_c6_cmdv", mem_cmd_valid, 1'b1);
      tick;
      mem_rvalid = 1'b1; mem_rdata = qb[0];
      chkw("bp_c7_rdata_old", line_rdata, rb);
      tick; mem_rdata = qb[1];
      tick; mem_rdata = qb[2];
      tick; mem_rdata = qb[3];
      chk1("bp_c10_resp", line_resp, 1'b0);
      chkw("bp_c10_rdata_old", line_rdata, rb);
      tick;
      mem_rvalid = 1'b0;
      chk1("bp_c11_resp", line_resp, 1'b1);
      chkw("bp_c11_rdata", line_rdata, qb);
      line_read = 1'b0;
      tick;

      // Read and write both high: write wins
      line_read = 1'b1; line_write = 1'b1; line_address = 32'h0000_0040;
      line_wdata = xb; mem_wready = 1'b1;
      tick;
      chk1("both_cmdw", mem_cmd_write, 1'b1);
      chkw("both_addr", 256'(mem_cmd_addr), 256'h0000_0040);
      tick;
      chk1("both_wv", mem_wvalid, 1'b1);
      chkw("both_beat0", 256'(mem_wdata), 256'(xb[0]));
      tick;
      chkw("both_beat1", 256'(mem_wdata), 256'(xb[1]));
      tick;
      chkw("both_beat2", 256'(mem_wdata), 256'(xb[2]));
      tick;
      chkw("both_beat3", 256'(mem_wdata), 256'(xb[3]));
      tick;
      chk1("both_resp", line_resp, 1'b1);
      chkw("both_rdata_hold", line_rdata, qb);
      line_read = 1'b0; line_write = 1'b0; mem_wready = 1'b0;
      tick;

      // Reset during the third read beat
      line_read = 1'b1; line_address = 32'h0000_2000;
      tick;
      tick;
      mem_rvalid = 1'b1; mem_rdata = zb[0];
      tick; mem_rdata = zb[1];
      tick; mem_rdata = zb[2];
      #2 rst_n = 1'b0;
      #1;
      chk1("mrst_resp", line_resp, 1'b0);
      chk1("mrst_cmdv", mem_cmd_valid, 1'b0);
      chk1("mrst_wv", mem_wvalid, 1'b0);
      chk1("mrst_cmdw", mem_cmd_write, 1'b0);
      chkw("mrst_addr", 256'(mem_cmd_addr), 256'h0);
      chkw("mrst_wdata", 256'(mem_wdata), 256'h0);
      chkw("mrst_rdata", line_rdata, 256'h0);
      line_read = 1'b0; mem_rvalid = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;

      // Fresh read after reset
      line_read = 1'b1; line_address = 32'hDEAD_BEEF; mem_cmd_ready = 1'b1;
      tick;
      chk1("post_cmdv", mem_cmd_valid, 1'b1);
      chkw("post_addr", 256'(mem_cmd_addr), 256'hDEAD_BEE0);
      tick;
      mem_rvalid = 1'b1; mem_rdata = nb[0];
      tick; mem_rdata = nb[1];
      tick; mem_rdata = nb[2];
      tick; mem_rdata = nb[3];
      chk1("post_c5_resp", line_resp, 1'b0);
      tick;
      mem_rvalid = 1'b0;
      chk1("post_c6_resp", line_resp, 1'b1);
      chkw("post_rdata", line_rdata, nb);
      line_read = 1'b0;
      tick;
      chk1("post_c7_resp", line_resp, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
